// File: rtl/instruction_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared definitions for the fetch stage: FSM state encodings, instruction
//   size, default bubble encoding, the IF/ID payload type and the address
//   range/alignment helpers used by the fetch control logic.
//   No ports (package).
// -----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  // Fetch FSM encodings (kept as plain constants for legacy compatibility)
  localparam logic [1:0] STATE_BOOT = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_HALT = 2'd2;

  localparam logic [63:0] INST_BYTES  = 64'd4;
  localparam logic [31:0] DEFAULT_NOP = 32'h00000013;  // addi x0,x0,0

  // Contents of the IF/ID pipeline register
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  // The compare is done in 65 bits so a PC close to 2^64 cannot wrap past
  // the limit and look in range.
  function automatic logic pc_out_of_range(input logic [63:0] pc,
                                           input logic [64:0] limit);
    logic [64:0] end_addr;
    end_addr = {1'b0, pc} + {1'b0, INST_BYTES};
    return (end_addr > limit);
  endfunction

  function automatic logic addr_misaligned(input logic [63:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Bundles the fetch stage's memory bus, hazard/branch controls and the
//   IF/ID outputs.
//   master : fetch unit side (drives Inst_Address, IF/ID and status flags)
//   slave  : environment side (memory, hazard unit, execute stage)
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Branch_Taken;
  logic [63:0] Branch_Target;
  logic [63:0] IF_ID_PC;
  logic [31:0] IF_ID_Instruction;
  logic        IF_ID_Valid;
  logic        Fetch_Fault;
  logic        Fetch_Halted;

  modport master (
    output Inst_Address, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
           Fetch_Fault, Fetch_Halted,
    input  Instruction, Stall, Branch_Taken, Branch_Target
  );

  modport slave (
    input  Inst_Address, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
           Fetch_Fault, Fetch_Halted,
    output Instruction, Stall, Branch_Taken, Branch_Target
  );
endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if_id_register
//   IF/ID pipeline register (pc, instruction, valid).
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset (loads a bubble)
//     flush        : load a bubble (highest priority)
//     hold         : keep current contents
//     load         : capture d
//     d / q        : payload in / registered payload out
// -----------------------------------------------------------------------------
module instruction_fetch_unit_if_id_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   flush,
  input  logic   hold,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t BUBBLE = '{pc: 64'd0, inst: NOP_INST, valid: 1'b0};

  if_id_t q_r;

  // Pipeline register update: flush > hold > load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r <= BUBBLE;
    end else if (flush) begin
      q_r <= BUBBLE;
    end else if (hold) begin
      q_r <= q_r;
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage in front of the instruction memory. Owns the PC (driven
//   straight out as Inst_Address), captures the returned instruction into
//   IF/ID, and handles stall, branch redirect/flush, misaligned-target fault
//   and end-of-memory halt.
//   Ports:
//     clk     : rising-edge clock
//     reset_n : asynchronous active-low reset
//     bus     : master side of instruction_fetch_unit_if
// -----------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] IMEM_BYTES = 64'd16,
  parameter logic [31:0] NOP_INST   = DEFAULT_NOP
) (
  input  logic                       clk,
  input  logic                       reset_n,
  instruction_fetch_unit_if.master   bus
);

  logic [63:0] pc_r;
  logic [63:0] pc_next_s;
  logic [63:0] pc_plus4_s;
  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic        fault_r;
  logic        fault_next_s;
  logic        halted_r;
  logic        range_bad_s;
  logic        flush_s;
  logic        hold_s;
  logic        load_s;
  if_id_t      if_id_d_s;
  if_id_t      if_id_q_s;

  assign pc_plus4_s  = pc_r + INST_BYTES;
  assign range_bad_s = pc_out_of_range(pc_r, {1'b0, IMEM_BYTES}) ||
                       addr_misaligned(pc_r);
  assign if_id_d_s   = '{pc: pc_r, inst: bus.Instruction, valid: 1'b1};

  // Next-state, next-PC and IF/ID control; branch > range > stall > normal
  always_comb begin
    pc_next_s    = pc_r;
    state_next_s = state_r;
    fault_next_s = fault_r;
    flush_s      = 1'b0;
    hold_s       = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      STATE_BOOT: begin
        flush_s      = 1'b1;
        state_next_s = STATE_RUN;
      end
      STATE_RUN: begin
        if (bus.Branch_Taken) begin
          flush_s = 1'b1;
          if (!addr_misaligned(bus.Branch_Target)) begin
            pc_next_s = bus.Branch_Target;
          end else begin
            fault_next_s = 1'b1;
            state_next_s = STATE_HALT;
          end
        end else if (range_bad_s) begin
          flush_s      = 1'b1;
          state_next_s = STATE_HALT;
        end else if (bus.Stall) begin
          hold_s = 1'b1;
        end else begin
          load_s    = 1'b1;
          pc_next_s = pc_plus4_s;
        end
      end
      STATE_HALT: begin
        flush_s = 1'b1;
      end
      default: begin
        // Unreachable encoding: park safely in HALT
        flush_s      = 1'b1;
        state_next_s = STATE_HALT;
      end
    endcase
  end

  // PC, FSM state and sticky status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r     <= RESET_PC;
      state_r  <= STATE_BOOT;
      fault_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      pc_r     <= pc_next_s;
      state_r  <= state_next_s;
      fault_r  <= fault_next_s;
      halted_r <= (state_next_s == STATE_HALT);
    end
  end

  instruction_fetch_unit_if_id_register #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush_s),
    .hold    (hold_s),
    .load    (load_s),
    .d       (if_id_d_s),
    .q       (if_id_q_s)
  );

  assign bus.Inst_Address      = pc_r;
  assign bus.IF_ID_PC          = if_id_q_s.pc;
  assign bus.IF_ID_Instruction = if_id_q_s.inst;
  assign bus.IF_ID_Valid       = if_id_q_s.valid;
  assign bus.Fetch_Fault       = fault_r;
  assign bus.Fetch_Halted      = halted_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit with a 16-byte preloaded
//   instruction memory. Observed tuple layout:
//   {Inst_Address, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid, Fault, Halted}
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I0  = 32'h00508093;
  localparam logic [31:0] I1  = 32'h00608093;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC   (64'h0),
    .IMEM_BYTES (64'd16),
    .NOP_INST   (NOP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: combinational read of the preloaded words
  always_comb begin
    case (bus.Inst_Address)
      64'h0:   bus.Instruction = I0;
      64'h4:   bus.Instruction = I1;
      64'h8:   bus.Instruction = I0;
      64'hC:   bus.Instruction = I1;
      default: bus.Instruction = 32'hDEADBEEF;
    endcase
  end

  function automatic logic [162:0] snap();
    return {bus.Inst_Address, bus.IF_ID_PC, bus.IF_ID_Instruction,
            bus.IF_ID_Valid, bus.Fetch_Fault, bus.Fetch_Halted};
  endfunction

  function automatic logic [162:0] mk(input logic [63:0] addr, input logic [63:0] pc,
                                      input logic [31:0] inst, input logic v,
                                      input logic f, input logic h);
    return {addr, pc, inst, v, f, h};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.Stall = 1'b0;
    bus.Branch_Taken = 1'b0;
    bus.Branch_Target = 64'd0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [162:0] got;
    logic [162:0] exp;
    bus.Stall = 1'b0;
    bus.Branch_Taken = 1'b0;
    bus.Branch_Target = 64'd0;
    reset_n = 1'b0;
    #12;
    exp = mk(64'h0, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_sequence();
    logic [162:0] got;
    logic [162:0] exp;
    logic [31:0]  words [4];
    words = '{I0, I1, I0, I1};
    apply_reset();
    exp = mk(64'h0, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL seq_pre_boot got=%h exp=%h", got, exp);
    end
    step();
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL seq_boot got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      exp = mk(64'(4 * (i + 1)), 64'(4 * i), words[i], 1'b1, 1'b0, 1'b0);
      got = snap();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL seq_fetch%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [162:0] got;
    logic [162:0] exp;
    apply_reset();
    repeat (3) step();
    bus.Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      exp = mk(64'h8, 64'h4, I1, 1'b1, 1'b0, 1'b0);
      got = snap();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL stall_hold%0d got=%h exp=%h", i, got, exp);
      end
    end
    bus.Stall = 1'b0;
    step();
    exp = mk(64'hC, 64'h8, I0, 1'b1, 1'b0, 1'b0);
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL stall_release got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_branch();
    logic [162:0] got;
    logic [162:0] exp;
    apply_reset();
    repeat (4) step();
    for (int r = 0; r < 2; r++) begin
      bus.Branch_Taken = 1'b1;
      bus.Branch_Target = 64'h4;
      bus.Stall = (r == 1);
      step();
      exp = mk(64'h4, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
      got = snap();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL branch_flush%0d got=%h exp=%h", r, got, exp);
      end
      bus.Branch_Taken = 1'b0;
      bus.Stall = 1'b0;
      step();
      exp = mk(64'h8, 64'h4, I1, 1'b1, 1'b0, 1'b0);
      got = snap();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL branch_target_fetch%0d got=%h exp=%h", r, got, exp);
      end
      step();
    end
  endtask

  task automatic test_misaligned_fault();
    logic [162:0] got;
    logic [162:0] exp;
    apply_reset();
    repeat (2) step();
    bus.Branch_Taken = 1'b1;
    bus.Branch_Target = 64'h6;
    step();
    exp = mk(64'h4, 64'h0, NOP, 1'b0, 1'b1, 1'b1);
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL fault_entry got=%h exp=%h", got, exp);
    end
    bus.Branch_Target = 64'h0;
    bus.Stall = 1'b1;
    repeat (2) step();
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL fault_sticky got=%h exp=%h", got, exp);
    end
    bus.Branch_Taken = 1'b0;
    bus.Stall = 1'b0;
  endtask

  task automatic test_end_of_memory();
    logic [162:0] got;
    logic [162:0] exp;
    apply_reset();
    repeat (5) step();
    exp = mk(64'h10, 64'hC, I1, 1'b1, 1'b0, 1'b0);
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL eom_last_fetch got=%h exp=%h", got, exp);
    end
    step();
    exp = mk(64'h10, 64'h0, NOP, 1'b0, 1'b0, 1'b1);
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL eom_halt got=%h exp=%h", got, exp);
    end
    bus.Branch_Taken = 1'b1;
    bus.Branch_Target = 64'h0;
    repeat (2) step();
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL eom_branch_ignored got=%h exp=%h", got, exp);
    end
    bus.Branch_Taken = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [162:0] got;
    logic [162:0] exp;
    apply_reset();
    repeat (3) step();
    bus.Branch_Taken = 1'b1;
    bus.Branch_Target = 64'h2;
    step();
    bus.Branch_Taken = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp = mk(64'h0, 64'h0, NOP, 1'b0, 1'b0, 1'b0);
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL midreset_async got=%h exp=%h", got, exp);
    end
    step();
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL midreset_held got=%h exp=%h", got, exp);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    got = snap();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL midreset_boot got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      exp = mk(64'(4 * (i + 1)), 64'(4 * i), ((i % 2) == 0) ? I0 : I1,
               1'b1, 1'b0, 1'b0);
      got = snap();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL midreset_fetch%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_branch();
    test_misaligned_fault();
    test_end_of_memory();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
